// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The slave view belongs to the adder; the master view to whoever drives and drains it.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  c_in,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output c_out,
        output ovf,
        output zero
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output c_in,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  c_out,
        input  ovf,
        input  zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one SLICE-bit ripple slice per stage, carry registered between stages.
// Whole pipeline advances together; a stalled output freezes every stage, bubbles included.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic          clk,
    input logic          rst_n,
    addsub_pipe_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int LAST   = NSLICE - 1;

    if (WIDTH <= 0 || SLICE <= 0 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a positive multiple of SLICE");
    end

    logic [WIDTH-1:0]  a_q [NSLICE];
    logic [WIDTH-1:0]  b_q [NSLICE];
    logic [WIDTH-1:0]  s_q [NSLICE];
    logic [NSLICE-1:0] c_q;
    logic [NSLICE-1:0] v_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  a_d [NSLICE];
    logic [WIDTH-1:0]  b_d [NSLICE];
    logic [WIDTH-1:0]  s_d [NSLICE];
    logic [NSLICE-1:0] c_d;
    logic [NSLICE-1:0] v_d;
    logic [NSLICE-1:0] ci_d;
    logic [SLICE:0]    part;
    logic              msb_ci;
    logic              ovf_d;
    logic              zero_d;
    logic              adv;

    assign adv = !v_q[LAST] || bus.out_ready;

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        s_d  = s_q;
        c_d  = '0;
        v_d  = '0;
        ci_d = '0;
        part = '0;

        // Stage 0 sees the raw operands; subtract is a + ~b + 1.
        a_d[0]  = bus.a;
        b_d[0]  = bus.sub ? ~bus.b : bus.b;
        s_d[0]  = '0;
        v_d[0]  = bus.in_valid;
        ci_d[0] = bus.c_in ^ bus.sub;
        for (int s = 1; s < NSLICE; s++) begin
            a_d[s]  = a_q[s-1];
            b_d[s]  = b_q[s-1];
            s_d[s]  = s_q[s-1];
            v_d[s]  = v_q[s-1];
            ci_d[s] = c_q[s-1];
        end

        for (int s = 0; s < NSLICE; s++) begin
            part = {1'b0, a_d[s][s*SLICE +: SLICE]}
                 + {1'b0, b_d[s][s*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, ci_d[s]};
            s_d[s][s*SLICE +: SLICE] = part[SLICE-1:0];
            c_d[s] = part[SLICE];
        end

        // Carry into the MSB recovered from the MSB's own sum bit.
        msb_ci = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1]
               ^ s_d[LAST][WIDTH-1];
        ovf_d  = msb_ci ^ c_d[LAST];
        zero_d = (s_d[LAST] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSLICE; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.c_out     = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
